// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package prog_clk_div_pkg;

    // Smallest ratio a channel will run at; 0 and 1 are promoted to this.
    localparam int unsigned MIN_DIV = 2;

    // Promote illegal ratios (0, 1) to the minimum usable ratio.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // Power-up ratio of channel ch: /2, /3, /4, /5 ... as on the legacy divider.
    function automatic logic [31:0] default_div(input int unsigned ch);
        return ch + MIN_DIV;
    endfunction

    // Width of the channel-select field; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control and output bundle of the programmable clock divider.
// Signalling: there is no ready/valid pair; en is a level, sync and cfg_we are
// single-cycle strobes sampled on every rising clk_in edge and always accepted.
// clk_out, tick and div_cur are registered and change only on that edge.
interface prog_clk_div_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    import prog_clk_div_pkg::*;

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0]       en;
    logic                    sync;
    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [DIV_W-1:0]        cfg_div;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*DIV_W-1:0] div_cur;

    modport master (
        output en, sync, cfg_we, cfg_ch, cfg_div,
        input  clk_out, tick, div_cur
    );

    modport slave (
        input  en, sync, cfg_we, cfg_ch, cfg_div,
        output clk_out, tick, div_cur
    );

endinterface

// File: rtl/prog_clk_div_ch.sv
// One divider channel: period counter, active/pending ratio and registered
// square-wave and period-start tick outputs. Ratio changes take effect only at
// a period boundary (or immediately while the channel is disabled).
module prog_clk_div_ch
    import prog_clk_div_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DEF_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [DIV_W-1:0] div_act_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic [DIV_W:0]   hi_len;

    // Next state: a write in the boundary cycle bypasses pend, so it is what gets loaded.
    always_comb begin
        div_pend_d = wr_i ? wr_div_i : div_pend_q;
        div_act_d  = div_act_q;
        cnt_d      = cnt_q + 1'b1;
        tick_d     = 1'b0;
        boundary   = (cnt_q == (div_act_q - 1'b1)) || sync_i;
        if (!en_i) begin
            // Parked at end-of-period so re-enable starts a fresh period.
            div_act_d = div_pend_d;
            cnt_d     = div_pend_d - 1'b1;
        end else if (boundary) begin
            div_act_d = div_pend_d;
            cnt_d     = '0;
            tick_d    = 1'b1;
        end
        // High for ceil(D/2) cycles of the ratio in effect for the new count.
        hi_len    = ({1'b0, div_act_d} + 1'b1) >> 1;
        clk_out_d = en_i && ({1'b0, cnt_d} < hi_len);
    end

    // State registers; reset leaves the counter at end-of-period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= DEF_DIV - 1'b1;
            div_act_q  <= DEF_DIV;
            div_pend_q <= DEF_DIV;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign div_act_o = div_act_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable clock divider. The top decodes ratio
// writes, fans sync out to every channel and packs the active ratios.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
) (
    input  logic          clk_in,
    input  logic          rst,
    prog_clk_div_if.slave bus
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [DIV_W-1:0]        wr_div;
    logic [NUM_CH-1:0]       clk_out_w;
    logic [NUM_CH-1:0]       tick_w;
    logic [NUM_CH*DIV_W-1:0] div_cur_w;

    // Clamp once here; every channel sees the already-legal ratio.
    assign wr_div = DIV_W'(clamp_div(32'(bus.cfg_div)));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        // Out-of-range channel indices match no channel and are dropped.
        assign wr_sel = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        prog_clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DIV_W'(default_div(i)))
        ) u_ch (
            .clk_i     (clk_in),
            .rst_i     (rst),
            .en_i      (bus.en[i]),
            .sync_i    (bus.sync),
            .wr_i      (wr_sel),
            .wr_div_i  (wr_div),
            .clk_out_o (clk_out_w[i]),
            .tick_o    (tick_w[i]),
            .div_act_o (div_cur_w[i*DIV_W +: DIV_W])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.div_cur = div_cur_w;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: a behavioural per-channel model predicts each
// edge, predictions are queued before the edge and compared after it.
module tb_prog_clk_div;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic clk_in = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [39:0] exp_q[$];

    // Behavioural model state: ratio in effect, pending ratio, position in period.
    int unsigned m_ratio[NUM_CH];
    int unsigned m_pend[NUM_CH];
    int unsigned m_phase[NUM_CH];
    logic [NUM_CH-1:0] m_out;
    logic [NUM_CH-1:0] m_tick;
    int hi_cnt[NUM_CH];
    int tk_cnt[NUM_CH];
    logic found;

    prog_clk_div_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();
    prog_clk_div_if #(.NUM_CH(3), .DIV_W(DIV_W)) bus3 ();

    prog_clk_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    // Three-channel copy: its 2-bit cfg_ch can address a nonexistent channel.
    prog_clk_div #(.NUM_CH(3), .DIV_W(DIV_W)) dut3 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus3)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_ratio[i] = i + 2;
            m_pend[i]  = i + 2;
            m_phase[i] = i + 1;
        end
        m_out  = '0;
        m_tick = '0;
    endtask

    // Predict the state after the coming rising edge from the inputs now applied.
    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            int unsigned pend;
            pend = m_pend[i];
            if (bus.cfg_we && bus.cfg_ch == i)
                pend = (bus.cfg_div < 2) ? 2 : bus.cfg_div;
            if (!bus.en[i]) begin
                m_ratio[i] = pend;
                m_phase[i] = pend - 1;
                m_tick[i]  = 1'b0;
                m_out[i]   = 1'b0;
            end else begin
                if (bus.sync || m_phase[i] == m_ratio[i] - 1) begin
                    m_ratio[i] = pend;
                    m_phase[i] = 0;
                    m_tick[i]  = 1'b1;
                end else begin
                    m_phase[i] = m_phase[i] + 1;
                    m_tick[i]  = 1'b0;
                end
                m_out[i] = (2 * m_phase[i] < m_ratio[i]);
            end
            m_pend[i] = pend;
        end
    endtask

    function automatic logic [39:0] model_word();
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < NUM_CH; i++) d[i*8 +: 8] = 8'(m_ratio[i]);
        return {d, m_tick, m_out};
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NUM_CH; i++) begin
            hi_cnt[i] = 0;
            tk_cnt[i] = 0;
        end
    endtask

    // One clock: push the prediction, take the edge, pop and compare, tally outputs.
    task automatic step();
        logic [39:0] e;
        model_edge();
        exp_q.push_back(model_word());
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check("clk_out", 32'(bus.clk_out), 32'(e[3:0]));
        check("tick", 32'(bus.tick), 32'(e[7:4]));
        check("div_cur", bus.div_cur, e[39:8]);
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.clk_out[i]) hi_cnt[i]++;
            if (bus.tick[i]) tk_cnt[i]++;
        end
    endtask

    task automatic set_cfg(input logic we, input logic [1:0] ch, input logic [7:0] d);
        bus.cfg_we  = we;
        bus.cfg_ch  = ch;
        bus.cfg_div = d;
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = '0;
        bus.sync     = 1'b0;
        set_cfg(1'b0, 2'd0, 8'd0);
        bus3.en      = '0;
        bus3.sync    = 1'b0;
        bus3.cfg_we  = 1'b0;
        bus3.cfg_ch  = '0;
        bus3.cfg_div = '0;
        model_reset();
        clear_counts();

        // Reset state.
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_clk_out", 32'(bus.clk_out), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_div_cur", bus.div_cur, 32'h05040302);
        check("rst_div_cur_3ch", 32'(bus3.div_cur), 32'h040302);

        // Free run with the legacy /2../5 set.
        rst    = 1'b0;
        bus.en = 4'hF;
        repeat (60) step();
        check("hi_ch0", hi_cnt[0], 30);
        check("hi_ch1", hi_cnt[1], 40);
        check("hi_ch2", hi_cnt[2], 30);
        check("hi_ch3", hi_cnt[3], 36);
        check("tk_ch0", tk_cnt[0], 30);
        check("tk_ch1", tk_cnt[1], 20);
        check("tk_ch2", tk_cnt[2], 15);
        check("tk_ch3", tk_cnt[3], 12);

        // Mid-period write to ch2: the /4 period finishes, then /7 runs.
        step();
        set_cfg(1'b1, 2'd2, 8'd7);
        step();
        set_cfg(1'b0, 2'd0, 8'd0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            found = bus.tick[2];
        end
        check("wait_tick_ch2", 32'(found), 1);
        check("div_cur_ch2_new", 32'(bus.div_cur[23:16]), 7);
        clear_counts();
        repeat (14) step();
        check("hi_ch2_div7", hi_cnt[2], 8);
        check("tk_ch2_div7", tk_cnt[2], 2);

        // Ratios 0 and 1 both clamp to 2.
        set_cfg(1'b1, 2'd1, 8'd0);
        step();
        set_cfg(1'b1, 2'd1, 8'd1);
        step();
        set_cfg(1'b0, 2'd0, 8'd0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            found = bus.tick[1];
        end
        check("wait_tick_ch1", 32'(found), 1);
        check("div_cur_ch1_clamp", 32'(bus.div_cur[15:8]), 2);
        clear_counts();
        repeat (10) step();
        check("hi_ch1_div2", hi_cnt[1], 5);
        check("tk_ch1_div2", tk_cnt[1], 5);

        // Write to a channel index that does not exist is dropped.
        bus3.cfg_we  = 1'b1;
        bus3.cfg_ch  = 2'd3;
        bus3.cfg_div = 8'd9;
        step();
        check("oob_write_ignored", 32'(bus3.div_cur), 32'h040302);
        bus3.cfg_ch = 2'd2;
        step();
        check("inrange_write_3ch", 32'(bus3.div_cur), 32'h090302);
        bus3.cfg_we = 1'b0;

        // sync aligns all enabled channels; disabled ch3 stays low.
        bus.en = 4'b0111;
        repeat (7) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_clk_out", 32'(bus.clk_out), 32'h7);
        check("sync_tick", 32'(bus.tick), 32'h7);
        repeat (12) step();

        // Drop en[0] while high: low next edge, no tick; re-raise restarts.
        found = bus.clk_out[0];
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            found = bus.clk_out[0];
        end
        check("wait_ch0_high", 32'(found), 1);
        bus.en[0] = 1'b0;
        step();
        check("dis_ch0_low", 32'(bus.clk_out[0]), 0);
        check("dis_ch0_notick", 32'(bus.tick[0]), 0);
        bus.en[0] = 1'b1;
        step();
        check("reen_ch0_tick", 32'(bus.tick[0]), 1);
        check("reen_ch0_high", 32'(bus.clk_out[0]), 1);

        // Write on the exact boundary cycle of ch3.
        bus.en = 4'hF;
        repeat (3) step();
        found = (m_phase[3] == m_ratio[3] - 1);
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            found = (m_phase[3] == m_ratio[3] - 1);
        end
        check("wait_ch3_end", 32'(found), 1);
        set_cfg(1'b1, 2'd3, 8'd9);
        step();
        set_cfg(1'b0, 2'd0, 8'd0);
        check("bnd_write_div_cur", 32'(bus.div_cur[31:24]), 9);
        check("bnd_write_tick", 32'(bus.tick[3]), 1);
        clear_counts();
        repeat (18) step();
        check("hi_ch3_div9", hi_cnt[3], 10);
        check("tk_ch3_div9", tk_cnt[3], 2);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_clk_out", 32'(bus.clk_out), 0);
        check("async_rst_tick", 32'(bus.tick), 0);
        check("async_rst_div_cur", bus.div_cur, 32'h05040302);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check("async_rst_div_cur_3ch", 32'(bus3.div_cur), 32'h040302);
        rst = 1'b0;
        clear_counts();
        repeat (20) step();
        check("post_rst_hi_ch0", hi_cnt[0], 10);
        check("post_rst_hi_ch3", hi_cnt[3], 12);
        check("post_rst_tk_ch3", tk_cnt[3], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
